// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit arbiter slice.
package uart_pkg;

  // Arbiter FSM: pick a requester, launch the byte, wait for the transmitter.
  typedef enum logic [1:0] {
    S_ARB    = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned DEF_NUM_REQ   = 4;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker. Searches upward from ptr+1 with wrap;
// when masked, only requester ptr (the lock owner) may win.
module rr_select
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         i_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  input  logic                       i_mask_en,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_index,
  output logic                       o_any
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [IW-1:0] w_cand;

  // First valid requester after ptr; offset NUM_REQ wraps back onto ptr itself.
  always_comb begin
    o_grant = '0;
    o_index = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    if (i_mask_en) begin
      if (i_valid[i_ptr]) begin
        o_grant[i_ptr] = 1'b1;
        o_index        = i_ptr;
        o_any          = 1'b1;
      end
    end else begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        w_cand = i_ptr + IW'(k);
        if (!o_any && i_valid[w_cand]) begin
          o_grant[w_cand] = 1'b1;
          o_index         = w_cand;
          o_any           = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_REQ byte streams onto a single UART transmitter, with
// packet locking (owner keeps the grant until req_last) and an idle-lock timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_start,
  output logic [DATA_BITS-1:0]         tx_din,
  input  logic                         tx_done,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         lock_timeout
);

  localparam int unsigned    IW      = $clog2(NUM_REQ);
  localparam int unsigned    CW      = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LIM = CW'(LOCK_TIMEOUT - 1);

  state_t                r_state;
  logic [IW-1:0]         r_ptr;
  logic                  r_lock;
  logic [CW-1:0]         r_cnt;
  logic [DATA_BITS-1:0]  r_tx_din;
  logic [IW-1:0]         r_grant_id;
  logic                  r_tx_start;
  logic                  r_busy;
  logic                  r_lock_timeout;

  logic [NUM_REQ-1:0]    w_grant;
  logic [IW-1:0]         w_idx;
  logic                  w_any;
  logic [DATA_BITS-1:0]  w_sel_data;

  // While locked, ptr equals the owner, so masking on ptr restricts to grant_id.
  rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .i_valid   (req_valid),
    .i_ptr     (r_ptr),
    .i_mask_en (r_lock),
    .o_grant   (w_grant),
    .o_index   (w_idx),
    .o_any     (w_any)
  );

  // Byte of the currently selected requester.
  always_comb begin
    w_sel_data = req_data[w_idx*DATA_BITS +: DATA_BITS];
  end

  // Ready is only offered while arbitrating; held low throughout reset.
  always_comb begin
    req_ready = (reset_n && (r_state == S_ARB)) ? w_grant : '0;
  end

  // Arbiter FSM with lock tracking, idle-lock counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_ARB;
      r_ptr          <= IW'(NUM_REQ - 1);
      r_lock         <= 1'b0;
      r_cnt          <= '0;
      r_tx_din       <= '0;
      r_grant_id     <= '0;
      r_tx_start     <= 1'b0;
      r_busy         <= 1'b0;
      r_lock_timeout <= 1'b0;
    end else begin
      r_tx_start     <= 1'b0;
      r_lock_timeout <= 1'b0;
      case (r_state)
        S_ARB: begin
          if (w_any) begin
            r_tx_din   <= w_sel_data;
            r_grant_id <= w_idx;
            r_ptr      <= w_idx;
            r_lock     <= ~req_last[w_idx];
            r_cnt      <= '0;
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_LAUNCH;
          end else if (r_lock) begin
            // Locked and the owner is idle: count toward forced release.
            if (r_cnt == CNT_LIM) begin
              r_lock         <= 1'b0;
              r_cnt          <= '0;
              r_lock_timeout <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            r_busy  <= 1'b0;
            r_state <= S_ARB;
          end
        end
        default: begin
          r_state <= S_ARB;
        end
      endcase
    end
  end

  assign tx_start     = r_tx_start;
  assign tx_din       = r_tx_din;
  assign grant_id     = r_grant_id;
  assign busy         = r_busy;
  assign lock_timeout = r_lock_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 requesters, 8-bit bytes, lock timeout 16).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        lock_timeout;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .DATA_BITS    (8),
    .NUM_REQ      (4),
    .LOCK_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done      (tx_done),
    .grant_id     (grant_id),
    .busy         (busy),
    .lock_timeout (lock_timeout)
  );

  // 10 ns system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task tick();
    @(posedge clk);
    #1;
  endtask

  task pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task do_reset();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_done   = 1'b0;
    reset_n   = 1'b0;
    tick();
    tick();
    reset_n   = 1'b1;
  endtask

  task test_reset();
    req_valid = '1;
    req_last  = '1;
    req_data  = 32'hDEAD_BEEF;
    tx_done   = 1'b0;
    reset_n   = 1'b1;
    #1;
    reset_n   = 1'b0;
    #2;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b want 0000", req_ready); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start got %b want 0", tx_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (lock_timeout !== 1'b0) begin errors++; $display("FAIL rst_lock_timeout got %b want 0", lock_timeout); end
    checks++; if (tx_din !== 8'h00) begin errors++; $display("FAIL rst_tx_din got %h want 00", tx_din); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id got %0d want 0", grant_id); end
    tick();
    tick();
    checks++; if (req_ready !== 4'b0000 || tx_start !== 1'b0) begin errors++; $display("FAIL rst_held got ready=%b start=%b want 0000/0", req_ready, tx_start); end
    reset_n   = 1'b1;
    req_valid = '0;
  endtask

  task test_single();
    do_reset();
    req_data[7:0] = 8'h55;
    req_last      = 4'b0001;
    req_valid     = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start got %b want 1", tx_start); end
    checks++; if (tx_din !== 8'h55) begin errors++; $display("FAIL single_din got %h want 55", tx_din); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_launch got %b want 1", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_launch got %b want 0000", req_ready); end
    tick();
    checks++; if (tx_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_wait got start=%b busy=%b want 0/1", tx_start, busy); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_wait got %b want 1", busy); end
    pulse_done();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", busy); end
    checks++; if (tx_din !== 8'h55) begin errors++; $display("FAIL single_din_hold got %h want 55", tx_din); end
  endtask

  task test_round_robin();
    logic [3:0] exp_rdy;
    logic [7:0] exp_din;
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'h10 + 8'(i);
    req_last  = '1;
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      exp_rdy = 4'b0001 << (n % 4);
      exp_din = 8'h10 + 8'(n % 4);
      #1;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", n, req_ready, exp_rdy); end
      tick();
      checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL rr_start[%0d] got %b want 1", n, tx_start); end
      checks++; if (grant_id !== 2'(n % 4)) begin errors++; $display("FAIL rr_grant[%0d] got %0d want %0d", n, grant_id, n % 4); end
      checks++; if (tx_din !== exp_din) begin errors++; $display("FAIL rr_din[%0d] got %h want %h", n, tx_din, exp_din); end
      tick();
      pulse_done();
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rr_start_gap[%0d] got %b want 0", n, tx_start); end
    end
    req_valid = '0;
  endtask

  task test_lock();
    do_reset();
    req_data[23:16] = 8'hA1;
    req_last        = 4'b0000;
    req_valid       = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lock_first_ready got %b want 0100", req_ready); end
    tick();
    checks++; if (tx_din !== 8'hA1 || grant_id !== 2'd2) begin errors++; $display("FAIL lock_first got din=%h id=%0d want a1/2", tx_din, grant_id); end
    req_data[7:0]   = 8'h30;
    req_data[15:8]  = 8'h31;
    req_data[23:16] = 8'hA2;
    req_last        = 4'b0111;
    req_valid       = 4'b0111;
    tick();
    pulse_done();
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lock_hold_ready got %b want 0100", req_ready); end
    tick();
    checks++; if (tx_din !== 8'hA2 || tx_start !== 1'b1) begin errors++; $display("FAIL lock_second got din=%h start=%b want a2/1", tx_din, tx_start); end
    req_data[23:16] = 8'hA3;
    tick();
    pulse_done();
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lock_release_ready got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task test_timeout();
    do_reset();
    req_data[15:8] = 8'h77;
    req_last       = 4'b0000;
    req_valid      = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL to_first_ready got %b want 0010", req_ready); end
    tick();
    req_valid       = 4'b0100;
    req_data[23:16] = 8'h88;
    req_last        = 4'b0100;
    tick();
    pulse_done();
    for (int c = 1; c <= 16; c++) begin
      checks++; if (req_ready !== 4'b0000 || lock_timeout !== 1'b0) begin errors++; $display("FAIL to_idle[%0d] got ready=%b pulse=%b want 0000/0", c, req_ready, lock_timeout); end
      tick();
    end
    checks++; if (lock_timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got %b want 1", lock_timeout); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL to_ready got %b want 0100", req_ready); end
    tick();
    checks++; if (tx_start !== 1'b1 || grant_id !== 2'd2 || tx_din !== 8'h88) begin errors++; $display("FAIL to_grant got start=%b id=%0d din=%h want 1/2/88", tx_start, grant_id, tx_din); end
    checks++; if (lock_timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_end got %b want 0", lock_timeout); end
  endtask

  task test_reset_mid();
    tick();
    req_valid = '0;
    reset_n   = 1'b0;
    #2;
    checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL mid_rst got busy=%b start=%b want 0/0", busy, tx_start); end
    checks++; if (grant_id !== 2'd0 || tx_din !== 8'h00) begin errors++; $display("FAIL mid_rst_regs got id=%0d din=%h want 0/00", grant_id, tx_din); end
    #2;
    reset_n = 1'b1;
    tick();
    pulse_done();
    checks++; if (tx_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_stale_done got start=%b busy=%b want 0/0", tx_start, busy); end
    tick();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_no_start got %b want 0", tx_start); end
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr_ready got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task test_done_in_launch();
    do_reset();
    req_data[7:0] = 8'h5A;
    req_last      = 4'b0001;
    req_valid     = 4'b0001;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++; if (busy !== 1'b1 || tx_start !== 1'b0) begin errors++; $display("FAIL dil_wait got busy=%b start=%b want 1/0", busy, tx_start); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL dil_ready got %b want 0000", req_ready); end
    tick();
    checks++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL dil_still got busy=%b ready=%b want 1/0000", busy, req_ready); end
    pulse_done();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dil_done_busy got %b want 0", busy); end
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL dil_regrant_ready got %b want 0001", req_ready); end
    tick();
    checks++; if (tx_start !== 1'b1 || tx_din !== 8'h5A) begin errors++; $display("FAIL dil_regrant got start=%b din=%h want 1/5a", tx_start, tx_din); end
    req_valid = '0;
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_mid();
    test_done_in_launch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set the byte width passed to the transmitter.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of requesters (power of two, 2..8).
REQ-003 Parameter LOCK_TIMEOUT, default 1024, SHALL set the cycle limit a packet lock may idle before forced release.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock, all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  NUM_REQ  per-requester byte available.
REQ-008 req_data  in  NUM_REQ*DATA_BITS  per-requester byte, requester i at slice [i*DATA_BITS +: DATA_BITS].
REQ-009 req_last  in  NUM_REQ  byte ends requester's packet.
REQ-010 req_ready  out  NUM_REQ  one-hot accept strobe.
REQ-011 tx_start  out  1  one-cycle launch pulse to transmitter.
REQ-012 tx_din  out  DATA_BITS  byte to transmitter, held stable from accept until next accept.
REQ-013 tx_done  in  1  transmitter completion pulse.
REQ-014 grant_id  out  log2(NUM_REQ)  index of current/last granted requester.
REQ-015 busy  out  1  high in S_LAUNCH and S_WAIT.
REQ-016 lock_timeout  out  1  one-cycle pulse on forced lock release.

Function
REQ-017 FSM states SHALL be S_ARB, S_LAUNCH, S_WAIT; S_ARB->S_LAUNCH on accept, S_LAUNCH->S_WAIT unconditionally, S_WAIT->S_ARB on tx_done.
REQ-018 In S_ARB, unlocked, selection SHALL be round-robin: first i with req_valid[i] searching from (ptr+1) mod NUM_REQ upward with wrap.
REQ-019 req_ready[g] SHALL be combinational, high only in S_ARB for the selected g; accept occurs on that edge (valid && ready).
REQ-020 On accept: tx_din<=req_data[g], grant_id<=g, ptr<=g, lock<=~req_last[g].
REQ-021 tx_start SHALL be high exactly in S_LAUNCH (cycle after accept); latency valid-in-S_ARB to tx_start = 1 cycle.
REQ-022 Back-to-back: tx_done in cycle T, next accept earliest T+1, tx_start T+2.
REQ-023 tx_done in S_ARB or S_LAUNCH SHALL be ignored.
REQ-024 While lock=1, S_ARB SHALL consider only requester grant_id; other req_ready stay 0.
REQ-025 Lock counter SHALL increment each S_ARB cycle with lock=1 and owner req_valid=0, clear on accept.
REQ-026 When counter reaches LOCK_TIMEOUT-1, lock SHALL clear, counter clear, lock_timeout pulse; arbitration resumes round-robin next cycle.
REQ-027 Accept of a byte with req_last=1 SHALL clear lock; ptr still equals owner so next grant moves on.
REQ-028 No req_valid in S_ARB: remain, outputs unchanged except req_ready=0.
REQ-029 Single requester streaming unlocked SHALL be re-granted each byte (round-robin wraps to itself).

Reset
REQ-030 reset_n low SHALL asynchronously force state S_ARB, ptr=NUM_REQ-1 (requester 0 first), lock=0, counter=0, tx_din=0, grant_id=0.
REQ-031 During/after reset outputs SHALL be tx_start=0, req_ready=0, busy=0, lock_timeout=0.
REQ-032 Reset mid-byte SHALL abandon the transfer; a stale tx_done afterwards is ignored per REQ-023.

Structure
REQ-033 Shared package uart_pkg SHALL hold the state enum type and default DATA_BITS/NUM_REQ constants.
REQ-034 Round-robin select SHALL be sub-module rr_select (combinational: valid vector, ptr, mask-enable -> one-hot grant, index, any).
REQ-035 Total RTL SHALL be 120-400 lines, no other sub-modules.

Verification
REQ-036 Reset release, req_valid=4'b0001, data 0x55, last=1 -> req_ready[0] one cycle, tx_start next cycle, tx_din=0x55, busy until tx_done.
REQ-037 All four valid continuously, last=1 -> grants 0,1,2,3,0 with tx_start two cycles after each tx_done.
REQ-038 Req 2 sends 0xA1 last=0, 0xA2 last=1 while req 0/1 valid -> both bytes from 2 consecutively, then grant 3 or 0 per pointer (0).
REQ-039 Req 1 locks (last=0) then drops valid, LOCK_TIMEOUT=16 -> lock_timeout pulse after 16 S_ARB cycles, next grant to req 2 if valid.
REQ-040 reset_n asserted in S_WAIT, then tx_done pulse after release -> no tx_start, state S_ARB, ptr favours requester 0.
REQ-041 tx_done injected in S_LAUNCH -> ignored, FSM still waits in S_WAIT for subsequent tx_done.
